// File: rtl/framebuffer_arbiter_pkg.sv
// Shared framebuffer geometry, read-owner tags and clear-engine state encoding.
package framebuffer_arbiter_pkg;

  localparam int FB_ADDR_W    = 9;
  localparam int FB_DATA_W    = 16;
  localparam int FB_WORDS_DEF = 512;

  // Which requester the RAM read data belongs to on the cycle after access.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DISP = 2'd1,
    OWN_CPU  = 2'd2
  } owner_e;

  typedef enum logic {
    CLR_IDLE   = 1'b0,
    CLR_ACTIVE = 1'b1
  } clrState_e;

endpackage

// File: rtl/fb_clear_engine.sv
// Hardware CLS sweep: writes zero to words 0..FB_WORDS-1, yielding to display fetches.
module fb_clear_engine
  import framebuffer_arbiter_pkg::*;
#(
  parameter int ADDR_W   = FB_ADDR_W,
  parameter int FB_WORDS = FB_WORDS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stall,
  output logic              busy,
  output logic [ADDR_W-1:0] ptr,
  output logic              wrEn
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FB_WORDS - 1);

  clrState_e         state, stateNxt;
  logic [ADDR_W-1:0] ptrNxt;
  logic              done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLR_IDLE;
      ptr   <= '0;
    end else begin
      state <= stateNxt;
      ptr   <= ptrNxt;
    end
  end

  always_comb begin
    stateNxt = state;
    ptrNxt   = ptr;
    wrEn     = 1'b0;
    done     = 1'b0;
    case (state)
      CLR_IDLE: begin
        if (start) stateNxt = CLR_ACTIVE;
      end
      CLR_ACTIVE: begin
        // A display fetch steals the slot; the pointer simply waits.
        if (!stall) begin
          wrEn = 1'b1;
          done = (ptr == LAST);
          if (done) begin
            stateNxt = CLR_IDLE;
            ptrNxt   = '0;
          end else begin
            ptrNxt = ptr + 1'b1;
          end
        end
      end
      default: stateNxt = CLR_IDLE;
    endcase
  end

  assign busy = (state == CLR_ACTIVE);

endmodule

// File: rtl/framebuffer_arbiter.sv
// Single-port framebuffer arbiter: display > clear > CPU.
// Optional hardware clear engine enabled by defining FB_CLEAR_ENGINE_EN.
module framebuffer_arbiter
  import framebuffer_arbiter_pkg::*;
#(
  parameter int ADDR_W   = FB_ADDR_W,
  parameter int DATA_W   = FB_DATA_W,
  parameter int FB_WORDS = FB_WORDS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  logic              clrBusy;
  logic              clrWr;
  logic [ADDR_W-1:0] clrPtr;
  logic              cpuBlock;

`ifdef FB_CLEAR_ENGINE_EN
  fb_clear_engine #(
    .ADDR_W   (ADDR_W),
    .FB_WORDS (FB_WORDS)
  ) uClr (
    .clk   (clk),
    .rst_n (rst_n),
    .start (clr_start),
    .stall (disp_req),
    .busy  (clrBusy),
    .ptr   (clrPtr),
    .wrEn  (clrWr)
  );
  // A clear request in the same cycle already outranks the CPU.
  assign cpuBlock = clrBusy | clr_start;
`else
  localparam int unusedWords = FB_WORDS;
  logic unusedClrStart;
  assign unusedClrStart = clr_start;
  assign clrBusy  = 1'b0;
  assign clrWr    = 1'b0;
  assign clrPtr   = '0;
  assign cpuBlock = 1'b0;
`endif

  logic [ADDR_W-1:0] lastAddr;
  owner_e            owner, ownNxt;
  logic [DATA_W-1:0] dispHold, cpuHold;

  assign cpu_gnt  = cpu_req & ~disp_req & ~cpuBlock;
  assign clr_busy = clrBusy;

  always_comb begin
    ram_addr  = lastAddr;
    ram_we    = 1'b0;
    ram_wdata = '0;
    ownNxt    = OWN_NONE;
    if (disp_req) begin
      ram_addr = disp_addr;
      ownNxt   = OWN_DISP;
    end else if (clrWr) begin
      ram_addr = clrPtr;
      ram_we   = 1'b1;
    end else if (cpu_gnt) begin
      ram_addr  = cpu_addr;
      ram_we    = cpu_we;
      ram_wdata = cpu_wdata;
      if (!cpu_we) ownNxt = OWN_CPU;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lastAddr <= '0;
      owner    <= OWN_NONE;
      dispHold <= '0;
      cpuHold  <= '0;
    end else begin
      lastAddr <= ram_addr;
      owner    <= ownNxt;
      if (owner == OWN_DISP) dispHold <= ram_rdata;
      if (owner == OWN_CPU)  cpuHold  <= ram_rdata;
    end
  end

  // Read data is forwarded straight from the RAM on its return cycle, then held.
  assign cpu_rvalid = (owner == OWN_CPU);
  assign cpu_rdata  = cpu_rvalid ? ram_rdata : cpuHold;
  assign disp_data  = (owner == OWN_DISP) ? ram_rdata : dispHold;

endmodule

// File: tb/tb_framebuffer_arbiter.sv
// Randomized bench with a cycle-level behavioural model of the framebuffer arbiter.
module tb_framebuffer_arbiter;

  localparam int AW = 9;
  localparam int DW = 16;
  localparam int NW = 512;
`ifdef FB_CLEAR_ENGINE_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic          clk, rst_n;
  logic          disp_req, cpu_req, cpu_we, cpu_gnt, cpu_rvalid, clr_start, clr_busy, ram_we;
  logic [AW-1:0] disp_addr, cpu_addr, ram_addr;
  logic [DW-1:0] disp_data, cpu_wdata, cpu_rdata, ram_wdata, ram_rdata;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] tbMem  [NW];
  logic [DW-1:0] gmem   [NW];
  logic [DW-1:0] preVal [NW];
  bit            doPreload;
  bit            dispOn, dispManual;
  logic [AW-1:0] manualAddr;

  bit            mBusy, pendD, pendC;
  int            mPtr, mLast;
  logic [DW-1:0] pendDv, pendCv, holdD, holdC;

  framebuffer_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(disp_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .clr_start(clr_start), .clr_busy(clr_busy),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port RAM, read-before-write, with a backdoor preload.
  always @(posedge clk) begin
    if (doPreload) begin
      for (int i = 0; i < NW; i++) tbMem[i] <= preVal[i];
    end else if (ram_we) begin
      tbMem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= tbMem[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: evaluated mid-cycle with that cycle's inputs, then advanced.
  always @(negedge clk) begin
    int  eAddr;
    bit  eWe, expGnt, wasBusy;
    logic [DW-1:0] eWd;
    if (doPreload) for (int i = 0; i < NW; i++) gmem[i] = preVal[i];
    if (!rst_n) begin
      chk("rst_cpu_gnt", 32'(cpu_gnt), 0);
      chk("rst_cpu_rvalid", 32'(cpu_rvalid), 0);
      chk("rst_cpu_rdata", 32'(cpu_rdata), 0);
      chk("rst_disp_data", 32'(disp_data), 0);
      chk("rst_clr_busy", 32'(clr_busy), 0);
      chk("rst_ram_we", 32'(ram_we), 0);
      chk("rst_ram_addr", 32'(ram_addr), 0);
      chk("rst_ram_wdata", 32'(ram_wdata), 0);
      mBusy = 0; mPtr = 0; mLast = 0; pendD = 0; pendC = 0; holdD = '0; holdC = '0;
    end else begin
      chk("cpu_rvalid", 32'(cpu_rvalid), 32'(pendC));
      chk("cpu_rdata", 32'(cpu_rdata), 32'(pendC ? pendCv : holdC));
      chk("disp_data", 32'(disp_data), 32'(pendD ? pendDv : holdD));
      if (pendC) holdC = pendCv;
      if (pendD) holdD = pendDv;
      pendC = 0; pendD = 0;
      chk("clr_busy", 32'(clr_busy), 32'(mBusy));
      wasBusy = mBusy;
      expGnt  = cpu_req && !disp_req && !mBusy && !(CLR_EN && clr_start);
      chk("cpu_gnt", 32'(cpu_gnt), 32'(expGnt));
      eWe = 0; eWd = '0;
      if (disp_req) begin
        eAddr = int'(disp_addr); pendD = 1; pendDv = gmem[disp_addr];
      end else if (mBusy) begin
        eAddr = mPtr; eWe = 1; gmem[mPtr] = '0;
        if (mPtr == NW - 1) begin mBusy = 0; mPtr = 0; end else mPtr++;
      end else if (expGnt) begin
        eAddr = int'(cpu_addr); eWe = cpu_we;
        if (cpu_we) begin eWd = cpu_wdata; gmem[cpu_addr] = cpu_wdata; end
        else begin pendC = 1; pendCv = gmem[cpu_addr]; end
      end else begin
        eAddr = mLast;
      end
      if (CLR_EN && clr_start && !wasBusy) mBusy = 1;
      chk("ram_addr", 32'(ram_addr), 32'(eAddr));
      chk("ram_we", 32'(ram_we), 32'(eWe));
      if (eWe) chk("ram_wdata", 32'(ram_wdata), 32'(eWd));
      mLast = eAddr;
    end
  end

  // Display: strobes at least 8 cycles apart when dispOn, else manual control.
  initial begin
    int gap;
    gap = 0;
    disp_req = 0; disp_addr = '0;
    forever begin
      @(posedge clk); #2;
      if (dispOn) begin
        if (gap == 0) begin
          disp_req = 1; disp_addr = AW'($urandom); gap = $urandom_range(7, 12);
        end else begin
          disp_req = 0; gap--;
        end
      end else begin
        disp_req = dispManual; disp_addr = manualAddr; gap = 0;
      end
    end
  end

  task automatic cpuOp(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input bit withClr, output int waited);
    bit g, done;
    cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d; clr_start = withClr;
    done = 0; waited = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      #2; g = cpu_gnt;
      @(posedge clk); #1;
      clr_start = 0;
      if (g) done = 1; else waited++;
    end
    cpu_req = 0; cpu_we = 0;
    chk("cpu_gnt_timeout", 32'(done), 1);
  endtask

  task automatic preloadRandom();
    for (int i = 0; i < NW; i++) preVal[i] = DW'($urandom) | 16'h0001;
    doPreload = 1;
    @(posedge clk); #1;
    doPreload = 0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int w, cnt, stalls, nz, keepDiff;
    rst_n = 0; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0; clr_start = 0;
    dispOn = 0; dispManual = 0; manualAddr = '0;
    for (int i = 0; i < NW; i++) preVal[i] = DW'($urandom) | 16'h0001;
    preVal[5] = 16'hA5A5;
    doPreload = 1;
    repeat (3) @(posedge clk);
    #1; doPreload = 0; rst_n = 1;

    // Display fetch of word 5
    dispManual = 1; manualAddr = 9'h005;
    @(posedge clk); #1; dispManual = 0;
    @(negedge clk);
    chk("t1_disp_data", 32'(disp_data), 32'h0000A5A5);
    chk("t1_cpu_rvalid", 32'(cpu_rvalid), 0);
    chk("t1_cpu_rdata", 32'(cpu_rdata), 0);
    @(posedge clk); #1;

    // CPU write then read back
    cpuOp(1, 9'h010, 16'hFFFF, 0, w);
    chk("t2_write_latency", 32'(w), 0);
    cpuOp(0, 9'h010, 16'h0000, 0, w);
    @(negedge clk);
    chk("t2_rvalid", 32'(cpu_rvalid), 1);
    chk("t2_rdata", 32'(cpu_rdata), 32'h0000FFFF);
    @(posedge clk); #1;

    // Display and CPU collide
    dispManual = 1; manualAddr = 9'h007;
    cpu_req = 1; cpu_we = 0; cpu_addr = 9'h005;
    #2; chk("t3_gnt_blocked", 32'(cpu_gnt), 0);
    @(posedge clk); #1; dispManual = 0;
    #2; chk("t3_gnt_next", 32'(cpu_gnt), 1);
    @(posedge clk); #1; cpu_req = 0;
    @(negedge clk);
    chk("t3_rdata", 32'(cpu_rdata), 32'h0000A5A5);
    @(posedge clk); #1;

    // Randomized traffic under a live display
    dispOn = 1;
    for (int n = 0; n < 300; n++) begin
      bit c;
      c = CLR_EN ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 3) == 0);
      cpuOp(1'($urandom), AW'($urandom), DW'($urandom), c, w);
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
    dispOn = 0;
    for (int i = 0; i < 1000 && mBusy; i++) begin @(posedge clk); #1; end
    repeat (2) begin @(posedge clk); #1; end

`ifdef FB_CLEAR_ENGINE_EN
    // Clear with no display, CPU requesting in the same cycle
    preloadRandom();
    clr_start = 1; cpu_req = 1; cpu_we = 0; cpu_addr = 9'h009;
    #2; chk("t4_gnt_blocked", 32'(cpu_gnt), 0);
    @(posedge clk); #1; clr_start = 0;
    cnt = 0; stalls = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (clr_busy) cnt++;
      else if (cnt > 0) break;
    end
    chk("t4_busy_cycles", 32'(cnt), 512);
    chk("t4_gnt_after", 32'(cpu_gnt), 1);
    @(posedge clk); #1; cpu_req = 0;
    @(posedge clk); #1;
    nz = 0;
    for (int i = 0; i < NW; i++) if (tbMem[i] != '0) nz++;
    chk("t4_nonzero_words", 32'(nz), 0);

    // Granted read followed by clear, display strobing throughout
    cpuOp(1, 9'h003, 16'h1234, 0, w);
    cpuOp(0, 9'h003, 16'h0000, 0, w);
    clr_start = 1; dispOn = 1;
    @(negedge clk);
    chk("t5_rvalid", 32'(cpu_rvalid), 1);
    chk("t5_rdata", 32'(cpu_rdata), 32'h00001234);
    @(posedge clk); #1; clr_start = 0;
    cnt = 0; stalls = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (clr_busy) begin cnt++; if (disp_req) stalls++; end
      else if (cnt > 0) break;
    end
    chk("t5_writes", 32'(cnt - stalls), 512);
    chk("t5_display_stalls_seen", 32'(stalls > 40), 1);
    @(posedge clk); #1; dispOn = 0;
    repeat (2) begin @(posedge clk); #1; end

    // Reset in the middle of a clear
    preloadRandom();
    clr_start = 1;
    @(posedge clk); #1; clr_start = 0;
    for (int i = 0; i < 2000 && mPtr != 256; i++) begin @(posedge clk); #1; end
    chk("t6_reached_0x100", 32'(mPtr), 256);
    rst_n = 0;
    #1; chk("t6_busy_in_reset", 32'(clr_busy), 0);
    repeat (2) @(posedge clk);
    #1; rst_n = 1;
    repeat (3) begin @(posedge clk); #1; end
    nz = 0; keepDiff = 0;
    for (int i = 0; i < 256; i++) if (tbMem[i] != '0) nz++;
    for (int i = 256; i < NW; i++) if (tbMem[i] != preVal[i]) keepDiff++;
    chk("t6_low_cleared", 32'(nz), 0);
    chk("t6_high_kept", 32'(keepDiff), 0);
`else
    // Without the clear engine, clr_start must not hold off the CPU
    clr_start = 1; cpu_req = 1; cpu_we = 0; cpu_addr = 9'h005;
    #2; chk("t4_noclr_gnt", 32'(cpu_gnt), 1);
    @(posedge clk); #1; clr_start = 0; cpu_req = 0;
    @(negedge clk);
    chk("t4_noclr_busy", 32'(clr_busy), 0);
    @(posedge clk); #1;
`endif

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
